// File: rtl/vec_stream_tx.sv
// Parallel-to-serial vector streamer with active + pending buffers, so vectors go out back-to-back.
// Optional m_last output is enabled by defining VEC_STREAM_TX_LAST_FLAG_EN.
module vec_stream_tx #(
   parameter int T  = 20,
   parameter int M  = 8,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [M*T-1:0]  load_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [T-1:0]    data_out,
   output logic            busy,
   output logic [CW-1:0]   vec_count
`ifdef VEC_STREAM_TX_LAST_FLAG_EN
   ,
   output logic            m_last
`endif
);

   // state  | meaning
   // IDLE   | active entry empty (pending is then empty too)
   // STREAM | active entry holds a vector being serialized
   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   logic [0:0]     r_state, w_state_nxt;
   logic [M*T-1:0] r_act, w_act_nxt;
   logic [M*T-1:0] r_pend, w_pend_nxt;
   logic           r_pend_full, w_pend_full_nxt;
   logic [IW-1:0]  r_idx, w_idx_nxt;
   logic [T-1:0]   r_data, w_data_nxt;
   logic           r_load_ready;
   logic [CW-1:0]  r_vec_count, w_vec_count_nxt;
   logic           w_act_full;
   logic           w_load_fire;
   logic           w_xfer;
   logic           w_last_xfer;

   assign w_act_full  = (r_state == S_STREAM);
   assign w_load_fire = load_valid && r_load_ready;
   assign w_xfer      = w_act_full && m_ready;
   assign w_last_xfer = w_xfer && (r_idx == IW'(M-1));

   always_comb begin
      w_state_nxt     = r_state;
      w_act_nxt       = r_act;
      w_pend_nxt      = r_pend;
      w_pend_full_nxt = r_pend_full;
      w_idx_nxt       = r_idx;
      w_vec_count_nxt = r_vec_count;
      case (r_state)
         S_IDLE: begin
            if (w_load_fire) begin
               w_state_nxt = S_STREAM;
               w_act_nxt   = load_data;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            if (w_last_xfer) begin
               w_vec_count_nxt = r_vec_count + 1'b1;
               w_idx_nxt       = '0;
               // load_ready is low while pending is full, so the two refill sources never collide
               if (r_pend_full) begin
                  w_act_nxt       = r_pend;
                  w_pend_full_nxt = 1'b0;
               end else if (w_load_fire) begin
                  w_act_nxt = load_data;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               if (w_xfer) begin
                  w_idx_nxt = r_idx + 1'b1;
               end
               if (w_load_fire) begin
                  w_pend_nxt      = load_data;
                  w_pend_full_nxt = 1'b1;
               end
            end
         end
      endcase
   end

   // Output word is registered from next-state so it already holds the element being offered.
   always_comb begin
      w_data_nxt = '0;
      if (w_state_nxt == S_STREAM) begin
         for (int i = 0; i < M; i++) begin
            if (w_idx_nxt == IW'(i)) begin
               w_data_nxt = w_act_nxt[i*T +: T];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_act        <= '0;
         r_pend       <= '0;
         r_pend_full  <= 1'b0;
         r_idx        <= '0;
         r_data       <= '0;
         r_load_ready <= 1'b1;
         r_vec_count  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_act        <= w_act_nxt;
         r_pend       <= w_pend_nxt;
         r_pend_full  <= w_pend_full_nxt;
         r_idx        <= w_idx_nxt;
         r_data       <= w_data_nxt;
         r_load_ready <= !w_pend_full_nxt;
         r_vec_count  <= w_vec_count_nxt;
      end
   end

`ifdef VEC_STREAM_TX_LAST_FLAG_EN
   logic r_last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last <= 1'b0;
      end else begin
         r_last <= (w_state_nxt == S_STREAM) && (w_idx_nxt == IW'(M-1));
      end
   end

   assign m_last = r_last;
`endif

   assign load_ready = r_load_ready;
   assign m_valid    = w_act_full;
   assign data_out   = r_data;
   assign busy       = w_act_full || r_pend_full;
   assign vec_count  = r_vec_count;

endmodule

// File: doc/vec_stream_tx.md
Name: vec_stream_tx

Overview:
- Producer side of the layer input stream (s_valid/s_ready/data_in on a layer).
- Accepts one whole M-element input vector in parallel and serializes it, element 0 first, onto a valid/ready word stream that feeds a layer's slave port.
- Two-entry buffer (active + pending) so the next vector loads while the current one streams.
- Back-to-back vectors go out with no idle cycle between them.

Parameters:
- T, 20, element width in bits (signed two's complement).
- M, 8, elements per vector; M >= 2.
- CW, 16, width of the completed-vector counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- load_valid  input  1  parallel vector offered.
- load_ready  output  1  vector slot free.
- load_data  input  M*T  vector; element i = load_data[i*T +: T].
- m_valid  output  1  stream word valid (drives layer s_valid).
- m_ready  input  1  downstream accepts (from layer s_ready).
- data_out  output  T  stream word, signed (drives layer data_in).
- busy  output  1  high when either buffer entry holds a vector.
- vec_count  output  CW  number of vectors fully streamed.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-low, on port reset: when reset == 0 at a rising edge, the block resets.
- Reset values:
  - m_valid = 0, data_out = 0, load_ready = 1, busy = 0, vec_count = 0.
  - Active and pending entries empty; elem_idx = 0.
  - Reset mid-stream discards both vectors; no partial-vector completion is counted.
- Handshakes:
  - Load fires when load_valid && load_ready.
  - Word transfers when m_valid && m_ready.
- load_ready:
  - Registered; load_ready = !pending_full.
  - Next-state value: pending is full after this edge → 0.
- Load routing at a load fire:
  - Active empty, or active finishing this cycle with pending empty → vector goes straight to active, elem_idx = 0.
  - Otherwise → vector goes into pending.
- Latency: load fires in cycle k → m_valid = 1 in cycle k+1 with data_out = element 0.
- Streaming:
  - While m_valid && !m_ready, data_out and m_valid hold stable.
  - On each transfer, elem_idx increments; data_out updates to the next element the following cycle.
- Last element (elem_idx == M-1) transfers:
  - vec_count increments, wrapping at 2^CW - 1 → 0.
  - elem_idx wraps to 0.
  - Pending full → pending moves to active, pending empties, load_ready rises next cycle. m_valid stays 1; next cycle presents element 0 of the new vector (zero bubble).
  - Pending empty and no simultaneous load → m_valid = 0, data_out = 0 next cycle.
  - Simultaneous load fire → the loaded vector becomes active directly (zero bubble).
- data_out is 0 whenever m_valid = 0.
- busy = active_full || pending_full.
- States:
  - IDLE: active empty. Load fire → STREAM.
  - STREAM: active full.
  - STREAM → IDLE only on the last-element transfer with pending empty and no load fire.
  - STREAM → STREAM on the last-element transfer when a refill occurs.
- No arithmetic on data; elements pass bit-exact.
- load_data is ignored when no load fires.
- m_ready is ignored while m_valid = 0.

Optional Feature:
- Macro: VEC_STREAM_TX_LAST_FLAG_EN.
- Defined:
  - Adds output port m_last (1 bit), = m_valid && (elem_idx == M-1); reset value 0.
  - Held stable under backpressure together with data_out.
- Undefined: port m_last is absent; all other behaviour is identical.

Test Plan:
- Reset/idle:
  - Stimulus: reset = 0 for 2 cycles, then reset = 1, no load.
  - Required: m_valid = 0, data_out = 0, load_ready = 1, busy = 0, vec_count = 0.
- Single vector, no backpressure:
  - Stimulus: load elements 1..8 with m_ready = 1.
  - Required: data_out = 1,2,...,8 on 8 consecutive cycles starting 1 cycle after the load; m_valid drops after 8; vec_count = 1. With the macro, m_last is high only on word 8.
- Backpressure:
  - Stimulus: load -5,-4,...,2 (elements -5 through 2); m_ready alternates 0/1 starting at 0.
  - Required: each word is held until accepted; order exact; negative values bit-exact (e.g. -5 = 20'hFFFFB); 16 cycles of m_valid; vec_count = 1.
- Back-to-back loads:
  - Stimulus: load A = 10..17 then B = 20..27 immediately, m_ready = 1.
  - Required: load_ready low after B is accepted until A's last word transfers; stream 10..17 then 20..27 with no m_valid gap; vec_count = 2.
- Simultaneous load and last transfer:
  - Stimulus: pending empty; assert load C = 30..37 in the cycle word 8 of A transfers.
  - Required: the next cycle presents 30 with m_valid = 1 (no bubble).
- Reset mid-stream:
  - Stimulus: reset = 0 after word 3 of a vector, with pending full.
  - Required: next cycle m_valid = 0, load_ready = 1, vec_count = 0; a new load afterwards streams from element 0.
